// File: rtl/stream_arb_2to1.sv
// Two-input round-robin stream arbiter feeding a single-entry output register, with per-source transfer counters.
// Latency: a word accepted at edge N is on out_data after edge N; readys drop while the output register is stalled.
module stream_arb_2to1 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_select,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  logic last_grant;
  logic load;
  logic grant_a;
  logic grant_b;

  // On contention the source that did not win last time is served.
  always_comb begin
    grant_a = a_valid && (!b_valid || last_grant);
    grant_b = b_valid && (!a_valid || !last_grant);
  end

  assign load    = !out_valid || out_ready;
  assign a_ready = rst_n && load && grant_a;
  assign b_ready = rst_n && load && grant_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_select <= 1'b0;
      last_grant <= 1'b1;
      a_count    <= '0;
      b_count    <= '0;
    end else if (a_valid && a_ready) begin
      out_valid  <= 1'b1;
      out_data   <= a_data;
      out_select <= 1'b0;
      last_grant <= 1'b0;
      a_count    <= a_count + 1'b1;
    end else if (b_valid && b_ready) begin
      out_valid  <= 1'b1;
      out_data   <= b_data;
      out_select <= 1'b1;
      last_grant <= 1'b1;
      b_count    <= b_count + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Directed vector bench for stream_arb_2to1; a second instance with 2-bit counters checks counter wrap.
module tb_stream_arb_2to1;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid, out_select;
  logic [7:0] out_data, a_count, b_count;
  logic       a_ready2, b_ready2, out_valid2, out_select2;
  logic [7:0] out_data2;
  logic [1:0] a_count2, b_count2;

  int n_cmp  = 0;
  int n_fail = 0;

  stream_arb_2to1 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_select(out_select),
    .out_ready(out_ready), .a_count(a_count), .b_count(b_count)
  );

  stream_arb_2to1 #(.DATA_W(8), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_select(out_select2),
    .out_ready(out_ready), .a_count(a_count2), .b_count(b_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       b_valid;
    logic [7:0] b_data;
    logic       out_ready;
    logic       exp_a_ready;
    logic       exp_b_ready;
    logic       exp_out_valid;
    logic [7:0] exp_out_data;
    logic       exp_out_select;
    logic [7:0] exp_a_count;
    logic [7:0] exp_b_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic av, logic [7:0] ad, logic bv, logic [7:0] bd,
                              logic ordy, logic ea, logic eb, logic eov, logic [7:0] eod,
                              logic eos, logic [7:0] eac, logic [7:0] ebc);
    vec_t v;
    v.rst_n = r; v.a_valid = av; v.a_data = ad; v.b_valid = bv; v.b_data = bd;
    v.out_ready = ordy; v.exp_a_ready = ea; v.exp_b_ready = eb; v.exp_out_valid = eov;
    v.exp_out_data = eod; v.exp_out_select = eos; v.exp_a_count = eac; v.exp_b_count = ebc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic ordy);
    rst_n = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    //                 rst av ad     bv bd     ordy  a_r b_r  ov od     os  ac    bc
    // reset, with a request that must not be acknowledged
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0,    0, 0,    0, 8'h00, 0, 8'd0, 8'd0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1,    0, 0,    0, 8'h00, 0, 8'd0, 8'd0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,    0, 0,    0, 8'h00, 0, 8'd0, 8'd0));
    // single source A
    vecs.push_back(mk(1, 1, 8'h3C, 0, 8'h00, 1,    1, 0,    1, 8'h3C, 0, 8'd1, 8'd0));
    // drain keeps data/select
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,    0, 0,    0, 8'h3C, 0, 8'd1, 8'd0));
    // single B so round-robin starts with A
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h5A, 1,    0, 1,    1, 8'h5A, 1, 8'd1, 8'd1));
    // round-robin, back-to-back replacement
    vecs.push_back(mk(1, 1, 8'hA0, 1, 8'hB0, 1,    1, 0,    1, 8'hA0, 0, 8'd2, 8'd1));
    vecs.push_back(mk(1, 1, 8'hA0, 1, 8'hB0, 1,    0, 1,    1, 8'hB0, 1, 8'd2, 8'd2));
    vecs.push_back(mk(1, 1, 8'hA0, 1, 8'hB0, 1,    1, 0,    1, 8'hA0, 0, 8'd3, 8'd2));
    vecs.push_back(mk(1, 1, 8'hA0, 1, 8'hB0, 1,    0, 1,    1, 8'hB0, 1, 8'd3, 8'd3));
    // backpressure: load A, stall 3 cycles, then B wins
    vecs.push_back(mk(1, 1, 8'hC1, 0, 8'h00, 1,    1, 0,    1, 8'hC1, 0, 8'd4, 8'd3));
    vecs.push_back(mk(1, 1, 8'hC2, 1, 8'hD2, 0,    0, 0,    1, 8'hC1, 0, 8'd4, 8'd3));
    vecs.push_back(mk(1, 1, 8'hC2, 1, 8'hD2, 0,    0, 0,    1, 8'hC1, 0, 8'd4, 8'd3));
    vecs.push_back(mk(1, 1, 8'hC2, 1, 8'hD2, 0,    0, 0,    1, 8'hC1, 0, 8'd4, 8'd3));
    vecs.push_back(mk(1, 1, 8'hC2, 1, 8'hD2, 1,    0, 1,    1, 8'hD2, 1, 8'd4, 8'd4));
    vecs.push_back(mk(1, 1, 8'hC2, 1, 8'hD2, 1,    1, 0,    1, 8'hC2, 0, 8'd5, 8'd4));
    // idle cycles do not rotate priority
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,    0, 0,    0, 8'hC2, 0, 8'd5, 8'd4));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,    0, 0,    0, 8'hC2, 0, 8'd5, 8'd4));
    vecs.push_back(mk(1, 1, 8'hE1, 1, 8'hE2, 1,    0, 1,    1, 8'hE2, 1, 8'd5, 8'd5));
    // stall then reset mid-transfer, then A wins first
    vecs.push_back(mk(1, 1, 8'hF1, 0, 8'h00, 0,    0, 0,    1, 8'hE2, 1, 8'd5, 8'd5));
    vecs.push_back(mk(0, 1, 8'hF1, 1, 8'hF2, 0,    0, 0,    0, 8'h00, 0, 8'd0, 8'd0));
    vecs.push_back(mk(1, 1, 8'hA3, 1, 8'hB3, 1,    1, 0,    1, 8'hA3, 0, 8'd1, 8'd0));
    vecs.push_back(mk(1, 1, 8'hA3, 1, 8'hB3, 1,    0, 1,    1, 8'hB3, 1, 8'd1, 8'd1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].a_valid, vecs[i].a_data,
            vecs[i].b_valid, vecs[i].b_data, vecs[i].out_ready);
      #3;
      check($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vecs[i].exp_a_ready));
      check($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(vecs[i].exp_b_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_out_data));
      check($sformatf("v%0d out_select", i), 32'(out_select), 32'(vecs[i].exp_out_select));
      check($sformatf("v%0d a_count", i), 32'(a_count), 32'(vecs[i].exp_a_count));
      check($sformatf("v%0d b_count", i), 32'(b_count), 32'(vecs[i].exp_b_count));
    end

    // 2-bit counter wrap: five B transfers give 1,2,3,0,1
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1;
    check("wrap reset b_count2", 32'(b_count2), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] exp2;
      exp2 = 2'(k);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 8'(8'h80 + k), 1'b1);
      #3;
      check($sformatf("wrap%0d b_ready2", k), 32'(b_ready2), 32'd1);
      @(posedge clk); #1;
      check($sformatf("wrap%0d b_count2", k), 32'(b_count2), 32'(exp2));
      check($sformatf("wrap%0d b_count", k), 32'(b_count), 32'(k));
      check($sformatf("wrap%0d out_data2", k), 32'(out_data2), 32'(8'h80 + k));
    end
    check("wrap a_count2", 32'(a_count2), 32'd0);

    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_arb_2to1.md
Name: stream_arb_2to1

Overview:
- Two-input round-robin stream arbiter with a registered output stage.
- Sits directly upstream of the 2-to-1 mux datapath. It arbitrates between source A and source B using valid/ready handshakes, and drives the select it chose.
- It captures the selected word into a single-entry output register and counts the transfers accepted from each source.

Parameters:
- DATA_W, 8, width of each data word.
- CNT_W, 8, width of each per-source transfer counter; the counters wrap.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a_valid  input  1  source A offers a_data.
- a_data  input  DATA_W  source A word.
- a_ready  output  1  source A word is accepted this cycle.
- b_valid  input  1  source B offers b_data.
- b_data  input  DATA_W  source B word.
- b_ready  output  1  source B word is accepted this cycle.
- out_valid  output  1  out_data holds a word.
- out_data  output  DATA_W  registered selected word.
- out_select  output  1  source of out_data: 0 = A, 1 = B.
- out_ready  input  1  downstream accepts the word.
- a_count  output  CNT_W  number of A transfers accepted, modulo 2^CNT_W.
- b_count  output  CNT_W  number of B transfers accepted, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - out_valid = 0, out_data = 0, out_select = 0.
  - a_count = 0, b_count = 0.
  - Internal last_grant = 1, so A has priority first.
  - Reset takes effect at the edge even mid-transfer; a held word is dropped.
  - While rst_n = 0, a_ready = b_ready = 0.
- Load enable: load = !out_valid || out_ready (register empty, or its word leaves this cycle).
- Grant, combinational from the valids and last_grant:
  - Only a_valid high: grant A.
  - Only b_valid high: grant B.
  - Both high: grant the source != last_grant.
  - Neither high: no grant.
- Ready outputs:
  - a_ready = load && grant A.
  - b_ready = load && grant B.
  - At most one ready is high in any cycle.
  - Ready may depend combinationally on out_ready and on both valids.
- Accept: a handshake (x_valid && x_ready) at the edge does all of the following:
  - out_data <= x_data.
  - out_select <= x (0 for A, 1 for B).
  - out_valid <= 1.
  - last_grant <= x.
  - x_count <= x_count + 1, wrapping from 2^CNT_W-1 to 0.
- Drain: if out_valid && out_ready and there is no accept, out_valid <= 0. out_data and out_select hold their last values.
- Stall: if out_valid && !out_ready:
  - out_data, out_select and out_valid hold.
  - Both readys are 0.
  - last_grant does not change, so arbitration fairness is preserved across the stall.
- Latency and throughput:
  - Input accepted at edge N appears on out_data after edge N.
  - Full throughput: one word per cycle when out_ready stays high.
  - Both sources continuously valid with out_ready high gives the strict sequence A, B, A, B...
- Source behaviour:
  - Sources must hold valid and data until ready.
  - The arbiter never grants a source whose valid is low.
  - last_grant changes only on an accept; idle cycles do not rotate priority.
- Simultaneous drain and accept in the same cycle gives a back-to-back replacement; out_valid stays 1.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n = 0 for 2 cycles, then rst_n = 1 with a_valid = b_valid = 0.
  - Required: out_valid = 0, out_data = 0, out_select = 0, counts = 0, a_ready = b_ready = 0.
- Single source:
  - Stimulus: a_valid = 1 with a_data = 8'h3C, out_ready = 1.
  - Required: a_ready = 1 that cycle; next cycle out_valid = 1, out_data = 8'h3C, out_select = 0, a_count = 1.
- Round-robin:
  - Stimulus: a_valid = b_valid = 1 for 4 cycles, a_data = 8'hA0, b_data = 8'hB0, out_ready = 1.
  - Required: out_data sequence A0, B0, A0, B0; out_select sequence 0, 1, 0, 1; a_count = 2, b_count = 2.
- Backpressure:
  - Stimulus: load one A word, then hold out_ready = 0 for 3 cycles with both valids high.
  - Required: a_ready = b_ready = 0; out_data is held.
  - Stimulus: release out_ready.
  - Required: B is granted next, since last_grant = A.
- Counter wrap:
  - Stimulus: CNT_W = 2, 5 consecutive B transfers.
  - Required: b_count = 1, i.e. 0 → 1 → 2 → 3 → 0 → 1.
- Reset mid-operation:
  - Stimulus: out_valid = 1 with out_ready = 0, then assert rst_n = 0 for one edge.
  - Required: out_valid = 0, counts = 0; the first grant after reset goes to A when both valids are high.
